// File: rtl/serial_adder_wide.sv
// serial_adder_wide: multi-cycle ripple adder/subtractor for wide operands.
// The block adds DIGIT bits per clock, starting at the LSB. The carry is held
// in a register from one digit to the next, so an operation takes
// WIDTH/DIGIT RUN cycles. A start/busy/done handshake connects it to the
// controlling FSM.
// Optional build macro SERIAL_ADD_OVF_EN adds an 'ovf' output. It carries the
// signed overflow of the completed operation.

module serial_adder_wide #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
    logic             msb_carry_in;
`endif

    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] part_shift;
    logic             last_digit;
    logic             accept;

    // Digit adder: the low DIGIT bits of both operands plus the stored carry.
    always_comb begin
        digit_sum  = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
        // The new digit enters at the MSB end and the oldest digit drops off.
        // Written as a shifted concatenation so DIGIT == WIDTH also works.
        part_shift = WIDTH'({digit_sum[DIGIT-1:0], part_q} >> DIGIT);
        last_digit = (count_q == CW'(N - 1));
`ifdef SERIAL_ADD_OVF_EN
        // Carry into the MSB is recovered from the MSB sum bit and its inputs.
        msb_carry_in = digit_sum[DIGIT-1] ^ op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1];
`endif
    end

    // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                busy    = 1'b1;
                op_a_d  = op_a_q >> DIGIT;
                op_b_d  = op_b_q >> DIGIT;
                part_d  = part_shift;
                carry_d = digit_sum[DIGIT];
                count_d = count_q + CW'(1);
                if (last_digit) begin
                    // The final digit goes straight to the visible result.
                    state_d = DONE;
                    sum_d   = part_shift;
                    cout_d  = digit_sum[DIGIT];
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = msb_carry_in ^ digit_sum[DIGIT];
`endif
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                accept  = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new request is taken in IDLE or in DONE. It overrides the
        // default return to IDLE. Subtract is done as A + ~B + 1.
        if (accept) begin
            state_d = RUN;
            op_a_d  = A;
            op_b_d  = sub ? ~B : B;
            carry_d = sub;
            count_d = '0;
        end
    end

    // State and datapath registers. Reset clears everything and aborts any
    // operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // pre-edge values, so statement order here does not matter.
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_wide.sv
// Testbench for serial_adder_wide. It drives two instances: 32/8 and 8/1.
// Stimulus pushes expected results, each tagged with the cycle it is due in,
// into a queue per instance. Per-instance monitors check busy, done, sum and
// cout (and ovf when SERIAL_ADD_OVF_EN is defined) on every falling edge.

module tb_serial_adder_wide;

    localparam int W32 = 32;
    localparam int D32 = 8;
    localparam int N32 = W32 / D32;
    localparam int W8  = 8;
    localparam int D8  = 1;
    localparam int N8  = W8 / D8;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub;
    logic [31:0] a, b;
    logic        busy, done, cout;
    logic [31:0] sum;
    logic        start8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
`ifdef SERIAL_ADD_OVF_EN
    logic        ovf, ovf8;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    exp_t q32[$];
    exp_t q8[$];
    int   acc32 = -1;
    int   acc8  = -1;
    exp_t cur32 = '{sum: '0, cout: 1'b0, ovf: 1'b0, cyc: 0};
    exp_t cur8  = '{sum: '0, cout: 1'b0, ovf: 1'b0, cyc: 0};

    serial_adder_wide #(.WIDTH(W32), .DIGIT(D32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(a), .B(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder_wide #(.WIDTH(W8), .DIGIT(D8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: modular add/subtract plus unsigned carry and signed overflow.
    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic s);
        logic [63:0] mask, xi, yi, r;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        xi = {32'd0, x} & mask;
        yi = {32'd0, y} & mask;
        if (!s) begin
            r      = xi + yi;
            e.cout = r[w];
        end else begin
            r      = xi - yi;
            e.cout = (xi >= yi);
        end
        r     = r & mask;
        e.sum = r[31:0];
        if (!s) e.ovf = (xi[w-1] == yi[w-1]) && (r[w-1] != xi[w-1]);
        else    e.ovf = (xi[w-1] != yi[w-1]) && (r[w-1] != xi[w-1]);
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [63:0] mask, v;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom % 5)
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = 64'd1 << (w - 1);
            3:       v = (64'd1 << (w - 1)) - 64'd1;
            default: v = {32'd0, $urandom} & mask;
        endcase
        return v[31:0];
    endfunction

    // Drive one cycle of 32/8 inputs; a start the model sees as idle is enqueued.
    task automatic drive32(input logic s_t, input logic [31:0] x, input logic [31:0] y,
                           input logic sb);
        exp_t e;
        @(negedge clk);
        #1;
        start = s_t; a = x; b = y; sub = sb;
        if (s_t && (acc32 < 0 || cyc + 1 >= acc32 + N32 + 1)) begin
            e = model(W32, x, y, sb);
            e.cyc = cyc + 1 + N32;
            q32.push_back(e);
            acc32 = cyc + 1;
        end
    endtask

    task automatic drive8(input logic s_t, input logic [7:0] x, input logic [7:0] y,
                          input logic sb);
        exp_t e;
        @(negedge clk);
        #1;
        start8 = s_t; a8 = x; b8 = y; sub8 = sb;
        if (s_t && (acc8 < 0 || cyc + 1 >= acc8 + N8 + 1)) begin
            e = model(W8, {24'd0, x}, {24'd0, y}, sb);
            e.cyc = cyc + 1 + N8;
            q8.push_back(e);
            acc8 = cyc + 1;
        end
    endtask

    // Monitor for the 32/8 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy32", 64'(busy), 64'(acc32 >= 0 && cyc >= acc32 && cyc < acc32 + N32));
            if (q32.size() > 0 && q32[0].cyc == cyc) begin
                check("done32", 64'(done), 64'd1);
                cur32 = q32.pop_front();
            end else begin
                check("done32", 64'(done), 64'd0);
            end
            check("sum32", 64'(sum), 64'(cur32.sum));
            check("cout32", 64'(cout), 64'(cur32.cout));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf32", 64'(ovf), 64'(cur32.ovf));
`endif
        end
    end

    // Monitor for the 8/1 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy8", 64'(busy8), 64'(acc8 >= 0 && cyc >= acc8 && cyc < acc8 + N8));
            if (q8.size() > 0 && q8[0].cyc == cyc) begin
                check("done8", 64'(done8), 64'd1);
                cur8 = q8.pop_front();
            end else begin
                check("done8", 64'(done8), 64'd0);
            end
            check("sum8", 64'(sum8), 64'(cur8.sum[7:0]));
            check("cout8", 64'(cout8), 64'(cur8.cout));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf8", 64'(ovf8), 64'(cur8.ovf));
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        #7;
        check("rst_busy32", 64'(busy), 64'd0);
        check("rst_done32", 64'(done), 64'd0);
        check("rst_sum32", 64'(sum), 64'd0);
        check("rst_cout32", 64'(cout), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_sum8", 64'(sum8), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Carry ripples through every digit.
        drive32(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        repeat (6) drive32(1'b0, '0, '0, 1'b0);
        // Subtract with and without borrow.
        drive32(1'b1, 32'd5, 32'd7, 1'b1);
        repeat (6) drive32(1'b0, '0, '0, 1'b0);
        drive32(1'b1, 32'd7, 32'd5, 1'b1);
        repeat (6) drive32(1'b0, '0, '0, 1'b0);
        // A second request while busy must be ignored.
        drive32(1'b1, 32'd1, 32'd1, 1'b0);
        drive32(1'b0, '0, '0, 1'b0);
        drive32(1'b1, 32'h10, 32'h20, 1'b0);
        repeat (6) drive32(1'b0, '0, '0, 1'b0);
        // Start held high: back-to-back operations.
        repeat (16) drive32(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        repeat (6) drive32(1'b0, '0, '0, 1'b0);

        // Reset in the middle of RUN aborts and clears the outputs.
        drive32(1'b1, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
        repeat (2) drive32(1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_sum", 64'(sum), 64'd0);
        check("arst_cout", 64'(cout), 64'd0);
        q32.delete();
        q8.delete();
        acc32 = -1;
        acc8 = -1;
        cur32 = '{sum: '0, cout: 1'b0, ovf: 1'b0, cyc: 0};
        cur8 = '{sum: '0, cout: 1'b0, ovf: 1'b0, cyc: 0};
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive32(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        repeat (6) drive32(1'b0, '0, '0, 1'b0);

        // Randomised traffic, including requests made while busy.
        for (int i = 0; i < 300; i++)
            drive32(($urandom % 3) == 0, pick(W32), pick(W32), 1'($urandom % 2));
        repeat (6) drive32(1'b0, '0, '0, 1'b0);

        // Bit-serial instance: signed overflow edge cases, then random traffic.
        drive8(1'b1, 8'h7F, 8'h01, 1'b0);
        repeat (10) drive8(1'b0, '0, '0, 1'b0);
        drive8(1'b1, 8'hFF, 8'h01, 1'b0);
        repeat (10) drive8(1'b0, '0, '0, 1'b0);
        drive8(1'b1, 8'h80, 8'h01, 1'b1);
        repeat (10) drive8(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 300; i++)
            drive8(($urandom % 4) == 0, 8'(pick(W8)), 8'(pick(W8)), 1'($urandom % 2));
        repeat (12) drive8(1'b0, '0, '0, 1'b0);

        check("pending32", 64'(q32.size()), 64'd0);
        check("pending8", 64'(q8.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_wide.md
Name: serial_adder_wide

Overview:
- Parametrised multi-cycle ripple adder/subtractor for wide operands (modular-arithmetic datapath).
- Processes DIGIT bits per clock from LSB upward, keeping the carry in a register between digits.
- Trades latency for area: WIDTH/DIGIT cycles per operation.
- Start/done handshake towards the controlling FSM.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits added per clock cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- sub  input  1  0: A+B, 1: A-B; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result
- cout  output  1  final carry (for subtract: 1 = no borrow, A>=B unsigned)

Behaviour:
- Reset is asynchronous and active-low, on a single clock:
  - busy, done, sum, cout, ovf (when present) go to 0.
  - Internal operand registers, carry and counter go to 0.
  - FSM goes to IDLE.
- N = WIDTH/DIGIT. Internal counter width is clog2(N)+1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: latch opA=A and opB = sub ? ~B : B; set carry=sub and count=0; go to RUN.
- RUN:
  - busy=1.
  - Each cycle compute the (DIGIT+1)-bit value opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Low DIGIT bits shift into the MSB end of the partial-result register (shift right by DIGIT).
  - Top bit becomes the new carry.
  - opA and opB shift right by DIGIT; count increments.
  - When count reaches N-1 (last digit), next state is DONE. The last digit's result is written straight into sum and its carry into cout on that same edge.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - If start=1 in DONE, it is accepted exactly as in IDLE: next state RUN, done still pulses that cycle.
  - Otherwise go to IDLE.
- Latency: start sampled at edge k, then done=1 during the cycle after edge k+N. The next operation can be accepted at edge k+N+1.
- sum/cout change only at completion. They hold their value through IDLE and through the next operation's RUN, until that operation completes.
- start, A, B and sub are ignored while busy=1. A request held across RUN is accepted in DONE.
- The arithmetic is plain two's-complement modulo 2^WIDTH. Subtract uses invert plus carry-in 1.
- If rst_n is asserted during RUN, the operation aborts. No done pulse occurs and outputs clear immediately.
- DIGIT=WIDTH is legal: N=1, single RUN cycle.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- When defined:
  - An extra output ovf (1 bit) is present.
  - ovf is the signed overflow of the completed operation, carry_into_MSB XOR carry_out_of_MSB.
  - It is registered alongside sum/cout, and resets to 0.
- When not defined: there is no ovf port and no overflow logic.

Test Plan:
- WIDTH=32, DIGIT=8: A=0xFFFFFFFF, B=0x00000001, sub=0, start pulse -> busy high 4 cycles, done pulses in 5th cycle after start edge, sum=0x00000000, cout=1.
- Subtract: A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0. Then A=7, B=5 -> sum=0x00000002, cout=1.
- start with A=1, B=1, then start again 2 cycles later with A=0x10, B=0x20 while busy -> second request ignored, sum=0x00000002, exactly one done pulse.
- Back-to-back: start held high continuously with 0x12345678+0x11111111 -> done pulses every 5 cycles, each sum=0x23456789, cout=0.
- Reset mid-operation: rst_n low for 1 cycle in RUN -> busy, done, sum and cout go to 0 asynchronously, no done pulse. The next start completes normally.
- WIDTH=8, DIGIT=1, SERIAL_ADD_OVF_EN defined: A=0x7F, B=0x01 -> done after 8 RUN cycles, sum=0x80, cout=0, ovf=1. With A=0xFF, B=0x01 -> sum=0x00, cout=1, ovf=0.
